route_reader: RTL
=================

ROUTE_READER -- requirements
Module: route_reader

Interface
REQ-001 DEPTH, 16, maximum number of stored moves (power of two, 2..16).
REQ-002 DIR_W, 2, width of one move code.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 push  input  1  solver appends pushDir to route top.
REQ-006 pushDir  input  DIR_W  move code to append.
REQ-007 pop  input  1  solver removes top entry (backtrack).
REQ-008 start  input  1  begin streaming stored route, oldest first.
REQ-009 clear  input  1  discard route, return to IDLE.
REQ-010 moveOut  output  DIR_W  current streamed move code.
REQ-011 moveValid  output  1  moveOut valid.
REQ-012 moveReady  input  1  consumer accepts moveOut.
REQ-013 count  output  $clog2(DEPTH)+1  stored entries.
REQ-014 empty / full  output  1 each  count==0 / count==DEPTH.
REQ-015 overflow  output  1  sticky: push attempted while full.
REQ-016 done  output  1  route completely streamed.

Function
REQ-017 FSM states IDLE, STREAM, DONE; encoding from shared package.
REQ-018 IDLE, push only, not full: mem[count] <= pushDir, count+1 next cycle.
REQ-019 IDLE, push only, full: storage and count unchanged, overflow <= 1.
REQ-020 IDLE, pop only, not empty: count-1; pop while empty ignored, no flag.
REQ-021 IDLE, push and pop same cycle, not empty: mem[count-1] <= pushDir, count unchanged; if empty, behaves as push only.
REQ-022 IDLE, start, count>0: next state STREAM, read pointer 0; push/pop in that cycle ignored.
REQ-023 IDLE, start, count==0: next state DONE directly, no moveValid pulse.
REQ-024 STREAM: moveValid=1, moveOut=mem[rdPtr]; first valid the cycle after start.
REQ-025 Transfer occurs only on moveValid & moveReady at clock edge; moveOut stable while moveValid & !moveReady.
REQ-026 Transfer with rdPtr<count-1: rdPtr+1, stay STREAM (back-to-back one move/cycle).
REQ-027 Transfer with rdPtr==count-1: next state DONE, moveValid 0 next cycle.
REQ-028 STREAM/DONE: push, pop, start ignored; count and storage frozen.
REQ-029 DONE: done=1 held until clear.
REQ-030 clear in any state (highest priority, overrides push/pop/start): next cycle IDLE, count 0, rdPtr 0, overflow 0, done 0; storage contents not cleared.
REQ-031 empty, full, count, done, moveValid decoded from registered state only (no input-to-output path except none); moveOut from registered storage and rdPtr.

Reset
REQ-032 rst low asynchronously forces IDLE, count 0, rdPtr 0, overflow 0; outputs moveValid 0, done 0, empty 1, full 0, moveOut 0.
REQ-033 rst mid-STREAM abandons route; no further moveValid until new start after release.
REQ-034 Storage array needs no reset.

Structure
REQ-035 Shared package maze_pkg holds move codes (UP=0, RIGHT=1, DOWN=2, LEFT=3), DIR_W, FSM state type.
REQ-036 Storage in one sub-module route_mem: DEPTH x DIR_W, one synchronous write port, one asynchronous read port; control/FSM in route_reader.

Verification
REQ-037 Reset, push UP,RIGHT,DOWN, start, moveReady=1 -> moveOut 0,1,2 on three consecutive cycles, then done=1, count=3.
REQ-038 Push RIGHT,RIGHT,LEFT, pop, push DOWN with push&pop same cycle -> stream yields RIGHT,DOWN; count=2.
REQ-039 Push 17 moves with DEPTH=16 -> full=1 after 16th, overflow=1 after 17th, stream yields only first 16.
REQ-040 Stream 4 moves, moveReady toggled 1,0,0,1,1,0,1 -> moveOut held during stalls, exactly 4 transfers, order preserved.
REQ-041 start with empty route -> done=1 next cycle, moveValid never high; clear -> IDLE, done=0.
REQ-042 rst low during STREAM after 2 of 5 transfers -> moveValid 0 immediately, count=0, empty=1; clear asserted with push same cycle -> count 0.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze-solver types: move codes, move width and the route reader FSM states.
package maze_pkg;

  localparam int DIR_W = 2;

  typedef enum logic [DIR_W-1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } move_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/route_mem.sv
// Route storage: DEPTH x WIDTH array with one synchronous write port and one combinational read port.
import maze_pkg::*;

module route_mem #(
  parameter int DEPTH = 16,
  parameter int WIDTH = DIR_W,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are never reset; the reader only streams entries written since the last clear.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/route_reader.sv
// Route stack for the maze solver: moves are pushed/popped while idle, then streamed oldest-first
// over a valid/ready handshake.
import maze_pkg::*;

module route_reader #(
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [DIR_W-1:0] pushDir,
  input  logic             pop,
  input  logic             start,
  input  logic             clear,
  output logic [DIR_W-1:0] moveOut,
  output logic             moveValid,
  input  logic             moveReady,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             done
);

  state_t          state_reg, state_next;
  logic [CW-1:0]   count_reg, count_next;
  logic [AW-1:0]   rd_ptr_reg, rd_ptr_next;
  logic            overflow_reg, overflow_next;

  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [DIR_W-1:0] mem_rdata;

  logic            is_empty;
  logic            is_full;
  logic            last_move;

  assign is_empty  = (count_reg == '0);
  assign is_full   = (count_reg == CW'(DEPTH));
  assign last_move = ({1'b0, rd_ptr_reg} == (count_reg - CW'(1)));

  route_mem #(
    .DEPTH(DEPTH),
    .WIDTH(DIR_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(pushDir),
    .raddr(rd_ptr_reg),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    rd_ptr_next   = rd_ptr_reg;
    overflow_next = overflow_reg;
    mem_we        = 1'b0;
    mem_waddr     = count_reg[AW-1:0];

    if (clear) begin
      state_next    = IDLE;
      count_next    = '0;
      rd_ptr_next   = '0;
      overflow_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            rd_ptr_next = '0;
            state_next  = is_empty ? DONE : STREAM;
          end else if (push && pop && !is_empty) begin
            // Simultaneous push/pop replaces the top entry in place.
            mem_we    = 1'b1;
            mem_waddr = count_reg[AW-1:0] - AW'(1);
          end else if (push) begin
            if (is_full) begin
              overflow_next = 1'b1;
            end else begin
              mem_we     = 1'b1;
              count_next = count_reg + CW'(1);
            end
          end else if (pop && !is_empty) begin
            count_next = count_reg - CW'(1);
          end
        end

        STREAM: begin
          if (moveReady) begin
            if (last_move) begin
              state_next = DONE;
            end else begin
              rd_ptr_next = rd_ptr_reg + AW'(1);
            end
          end
        end

        DONE: begin
          state_next = DONE;
        end

        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign moveValid = (state_reg == STREAM);
  assign done      = (state_reg == DONE);
  assign count     = count_reg;
  assign empty     = is_empty;
  assign full      = is_full;
  assign overflow  = overflow_reg;
  // Storage is unreset, so gate the read data to keep moveOut at zero outside streaming.
  assign moveOut   = moveValid ? mem_rdata : '0;

endmodule
